// File: rtl/key_expansion.sv
// key_expansion: sequential AES key-schedule generator.
//
// Expands an Nk-word cipher key into the full 4*(Nr+1)-word schedule, one
// word per clock, and presents it as a flat bus for the Cipher stage.
//
// Ports:
//   clks    - clock, rising edge
//   reset   - synchronous, active-high, highest priority
//   start   - single-cycle request to expand key_in (ignored while busy)
//   key_in  - cipher key, word j at key_in[32j +: 32]
//   busy    - expansion in progress
//   done    - keys holds a complete schedule (level)
//   keys    - expanded schedule, word w[i] at keys[32i +: 32],
//             round key r at keys[128r +: 128]
module key_expansion #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                     clks,
  input  logic                     reset,
  input  logic                     start,
  input  logic [Nk*32-1:0]         key_in,
  output logic                     busy,
  output logic                     done,
  output logic [128*(Nr+1)-1:0]    keys
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW);
  localparam int PW = $clog2(Nk);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   i;
  logic [PW-1:0]   phase;   // tracks i mod Nk without a divider
  logic [7:0]      rcon;
  logic [31:0]     w [NW];
  logic [31:0]     temp;
  logic [31:0]     w_new;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Next schedule word from w[i-1] and w[i-Nk].
  always_comb begin
    temp = w[i - IW'(1)];
    if (phase == '0) begin
      temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
    end else if (Nk == 8 && phase == PW'(4)) begin
      temp = sub_word(temp);
    end
    w_new = w[i - IW'(Nk)] ^ temp;
  end

  always_ff @(posedge clks) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      i     <= '0;
      phase <= '0;
      rcon  <= 8'h01;
      w     <= '{default: '0};
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int unsigned k = 0; k < NW; k++) begin
              if (k < Nk) w[IW'(k)] <= key_in[32*k +: 32];
              else        w[IW'(k)] <= '0;
            end
            i     <= IW'(Nk);
            phase <= '0;
            rcon  <= 8'h01;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= EXPAND;
          end
        end
        EXPAND: begin
          w[i] <= w_new;
          if (phase == '0) rcon <= xtime(rcon);
          phase <= (phase == PW'(Nk - 1)) ? '0 : phase + PW'(1);
          i     <= i + IW'(1);
          if (i == IW'(NW - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    keys = '0;
    for (int unsigned k = 0; k < NW; k++) keys[32*k +: 32] = w[IW'(k)];
  end

endmodule
